// File: rtl/sga_serial_pkg.sv
// Shared definitions for the 7O1 serial command receiver:
// FSM codes, ASCII command set, direction encodings, default baud divider.
package sga_serial_pkg;

    localparam int CLKS_PER_BIT_DEF = 434;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DECODE = 3'd5
    } rx_state_t;

    localparam logic [6:0] CMD_RIGHT   = 7'h64;
    localparam logic [6:0] CMD_LEFT    = 7'h61;
    localparam logic [6:0] CMD_UP      = 7'h77;
    localparam logic [6:0] CMD_DOWN    = 7'h73;
    localparam logic [6:0] CMD_START   = 7'h69;
    localparam logic [6:0] CMD_RESTART = 7'h72;
    localparam logic [6:0] CMD_PAUSE   = 7'h70;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

endpackage

// File: rtl/rx_serial_7o1.sv
// 7-data / odd-parity / 1-stop serial receiver with input synchronizer.
// Presents one DECODE cycle per frame carrying data and per-frame error bits.
module rx_serial_7o1
    import sga_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_in,
    output logic       frame_valid,
    output logic [6:0] frame_data,
    output logic       frame_perr,
    output logic       frame_ferr,
    output logic [2:0] state_code
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t     state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic          prev_q, prev_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [6:0]    shift_q, shift_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          line;
    logic          tick_full;
    logic          tick_half;

    assign line      = sync_q[1];
    assign tick_full = (baud_q == CNT_FULL);
    assign tick_half = (baud_q == CNT_HALF);

    always_comb begin
        sync_d  = {sync_q[0], rx_in};
        prev_d  = line;
        state_d = state_q;
        baud_d  = baud_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        unique case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (prev_q && !line) begin
                    state_d = ST_START;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            ST_START: begin
                if (tick_half) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = line ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick_full) begin
                    baud_d  = '0;
                    shift_d = {line, shift_q[6:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd6) state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (tick_full) begin
                    baud_d  = '0;
                    perr_d  = ~(^{shift_q, line});
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick_full) begin
                    baud_d  = '0;
                    ferr_d  = ~line;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                baud_d  = '0;
                state_d = ST_IDLE;
            end
            default: begin
                baud_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign frame_valid = (state_q == ST_DECODE);
    assign frame_data  = shift_q;
    assign frame_perr  = perr_q;
    assign frame_ferr  = ferr_q;
    assign state_code  = state_q;

endmodule

// File: rtl/sga_serial_rx_cmd.sv
// Serial command receiver: maps received ASCII keys onto game controls
// and keeps sticky line-error flags until the next clean frame.
module sga_serial_rx_cmd
    import sga_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    output logic [1:0] direction,
    output logic       dir_valid,
    output logic       start_pulse,
    output logic       restart_pulse,
    output logic       pause,
    output logic [6:0] dado,
    output logic       parity_error,
    output logic       framing_error,
    output logic [2:0] db_state
);

    logic       frame_valid;
    logic [6:0] frame_data;
    logic       frame_perr;
    logic       frame_ferr;

    logic [1:0] dir_q, dir_d;
    logic       dv_q, dv_d;
    logic       start_q, start_d;
    logic       restart_q, restart_d;
    logic       pause_q, pause_d;
    logic [6:0] dado_q, dado_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;

    rx_serial_7o1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock       (clock),
        .reset       (reset),
        .rx_in       (entrada_serial),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .frame_perr  (frame_perr),
        .frame_ferr  (frame_ferr),
        .state_code  (db_state)
    );

    always_comb begin
        dir_d     = dir_q;
        dv_d      = 1'b0;
        start_d   = 1'b0;
        restart_d = 1'b0;
        pause_d   = pause_q;
        dado_d    = dado_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        if (frame_valid) begin
            dado_d = frame_data;
            if (frame_perr || frame_ferr) begin
                perr_d = perr_q | frame_perr;
                ferr_d = ferr_q | frame_ferr;
            end else begin
                perr_d = 1'b0;
                ferr_d = 1'b0;
                case (frame_data)
                    CMD_RIGHT:   begin dir_d = DIR_RIGHT; dv_d = 1'b1; end
                    CMD_LEFT:    begin dir_d = DIR_LEFT;  dv_d = 1'b1; end
                    CMD_UP:      begin dir_d = DIR_UP;    dv_d = 1'b1; end
                    CMD_DOWN:    begin dir_d = DIR_DOWN;  dv_d = 1'b1; end
                    CMD_START:   start_d   = 1'b1;
                    CMD_RESTART: restart_d = 1'b1;
                    CMD_PAUSE:   pause_d   = ~pause_q;
                    default:     ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dir_q     <= DIR_RIGHT;
            dv_q      <= 1'b0;
            start_q   <= 1'b0;
            restart_q <= 1'b0;
            pause_q   <= 1'b0;
            dado_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            dir_q     <= dir_d;
            dv_q      <= dv_d;
            start_q   <= start_d;
            restart_q <= restart_d;
            pause_q   <= pause_d;
            dado_q    <= dado_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign direction     = dir_q;
    assign dir_valid     = dv_q;
    assign start_pulse   = start_q;
    assign restart_pulse = restart_q;
    assign pause         = pause_q;
    assign dado          = dado_q;
    assign parity_error  = perr_q;
    assign framing_error = ferr_q;

endmodule

// File: tb/tb_sga_serial_rx_cmd.sv
// Scoreboard bench for sga_serial_rx_cmd: serial frames in, expected
// control/flag state queued per frame and checked after each DECODE.
module tb_sga_serial_rx_cmd;

    localparam int CLKS = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       entrada_serial = 1'b1;
    logic [1:0] direction;
    logic       dir_valid;
    logic       start_pulse;
    logic       restart_pulse;
    logic       pause;
    logic [6:0] dado;
    logic       parity_error;
    logic       framing_error;
    logic [2:0] db_state;

    sga_serial_rx_cmd #(.CLKS_PER_BIT(CLKS)) dut (
        .clock         (clock),
        .reset         (reset),
        .entrada_serial(entrada_serial),
        .direction     (direction),
        .dir_valid     (dir_valid),
        .start_pulse   (start_pulse),
        .restart_pulse (restart_pulse),
        .pause         (pause),
        .dado          (dado),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .db_state      (db_state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [6:0] dado;
        logic [1:0] dir;
        logic       pause;
        logic       perr;
        logic       ferr;
        logic       dv;
        logic       st;
        logic       rs;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;

    logic [1:0] m_dir;
    logic       m_pause;
    logic       m_perr;
    logic       m_ferr;
    logic [6:0] m_dado;
    int         m_pulses = 0;
    int         seen_pulses = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: what a frame should do to the visible state.
    task automatic model_frame(input logic [6:0] d, input bit pe, input bit fe);
        exp_t e;
        e.dv = 0;
        e.st = 0;
        e.rs = 0;
        m_dado = d;
        if (pe || fe) begin
            m_perr = m_perr | pe;
            m_ferr = m_ferr | fe;
        end else begin
            m_perr = 0;
            m_ferr = 0;
            if (d == 7'h64) begin m_dir = 2'd0; e.dv = 1; end
            if (d == 7'h61) begin m_dir = 2'd1; e.dv = 1; end
            if (d == 7'h77) begin m_dir = 2'd2; e.dv = 1; end
            if (d == 7'h73) begin m_dir = 2'd3; e.dv = 1; end
            if (d == 7'h69) e.st = 1;
            if (d == 7'h72) e.rs = 1;
            if (d == 7'h70) m_pause = ~m_pause;
        end
        m_pulses += int'(e.dv) + int'(e.st) + int'(e.rs);
        e.dado  = m_dado;
        e.dir   = m_dir;
        e.pause = m_pause;
        e.perr  = m_perr;
        e.ferr  = m_ferr;
        sbq.push_back(e);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_dir"}, int'(direction), int'(m_dir));
        chk({tag, "_pause"}, int'(pause), int'(m_pause));
        chk({tag, "_dado"}, int'(dado), int'(m_dado));
        chk({tag, "_perr"}, int'(parity_error), int'(m_perr));
        chk({tag, "_ferr"}, int'(framing_error), int'(m_ferr));
        chk({tag, "_state"}, int'(db_state), 0);
    endtask

    task automatic do_reset();
        entrada_serial = 1'b1;
        reset = 1'b0;
        m_dir = 0;
        m_pause = 0;
        m_perr = 0;
        m_ferr = 0;
        m_dado = 0;
        sbq.delete();
        repeat (3) @(posedge clock);
        #1;
        check_state("reset");
        chk("reset_pulses", int'(dir_valid) + int'(start_pulse) + int'(restart_pulse), 0);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v);
        entrada_serial = v;
        repeat (CLKS) @(posedge clock);
        #1;
    endtask

    // abort_at >= 0 asserts reset just before that frame bit index.
    task automatic send(input logic [6:0] d, input bit pflip, input bit stop0,
                        input int gap, input int abort_at);
        logic [8:0] bits;
        bits = {~stop0, (~^d) ^ pflip, d};
        if (abort_at < 0) model_frame(d, pflip, stop0);
        drive(1'b0);
        for (int i = 0; i < 9; i++) begin
            if (i == abort_at) begin
                do_reset();
                return;
            end
            drive(bits[i]);
        end
        for (int g = 0; g < gap; g++) drive(1'b1);
    endtask

    always @(negedge clock) begin
        seen_pulses += int'(dir_valid) + int'(start_pulse) + int'(restart_pulse);
    end

    always @(negedge clock) begin
        if (reset && db_state == 3'd5) begin
            @(negedge clock);
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame: got dado %0h expected no frame", dado);
            end else begin
                mon_e = sbq.pop_front();
                chk("frm_dado", int'(dado), int'(mon_e.dado));
                chk("frm_dir", int'(direction), int'(mon_e.dir));
                chk("frm_pause", int'(pause), int'(mon_e.pause));
                chk("frm_perr", int'(parity_error), int'(mon_e.perr));
                chk("frm_ferr", int'(framing_error), int'(mon_e.ferr));
                chk("frm_dv", int'(dir_valid), int'(mon_e.dv));
                chk("frm_start", int'(start_pulse), int'(mon_e.st));
                chk("frm_restart", int'(restart_pulse), int'(mon_e.rs));
            end
        end
    end

    logic [6:0] cmds [7];
    logic [6:0] d;
    bit         pf;
    bit         sf;

    initial begin
        cmds = '{7'h64, 7'h61, 7'h77, 7'h73, 7'h69, 7'h72, 7'h70};
        #2;
        do_reset();

        send(7'h77, 0, 0, 1, -1);
        send(7'h70, 0, 0, 0, -1);
        send(7'h70, 0, 0, 1, -1);
        send(7'h69, 1, 0, 0, -1);
        send(7'h72, 0, 0, 1, -1);
        send(7'h61, 0, 1, 1, -1);
        send(7'h64, 1, 0, 1, -1);

        entrada_serial = 1'b0;
        repeat (CLKS / 4) @(posedge clock);
        #1;
        entrada_serial = 1'b1;
        repeat (2 * CLKS) @(posedge clock);
        #1;
        check_state("glitch");

        send(7'h73, 0, 0, 0, 3);
        send(7'h64, 0, 0, 1, -1);
        send(7'h61, 0, 0, 1, -1);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 6) d = cmds[$urandom_range(0, 6)];
            else d = 7'($urandom_range(0, 127));
            pf = ($urandom_range(0, 9) == 0);
            sf = ($urandom_range(0, 9) == 0);
            send(d, pf, sf, sf ? 1 : int'($urandom_range(0, 2)), -1);
        end

        drive(1'b1);
        for (int t = 0; t < 20 * CLKS && sbq.size() != 0; t++) @(posedge clock);
        repeat (4) @(posedge clock);
        #1;
        chk("queue_drained", sbq.size(), 0);
        chk("pulse_count", seen_pulses, m_pulses);
        check_state("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
